// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : WolfCore decode / operand-fetch stage. Splits the instruction
//            word, selects A/B operands (GPR, PC, overflow, sign-extended
//            immediate), bypasses EX/WB results, detects load-use hazards and
//            registers everything into the execute stage under stall/flush.
// Config   : OPERAND_FWD_EN - when defined, EX/WB bypass is enabled and only
//            load-use raises hazard_stall; when undefined, operands come from
//            r_flat only and any used-GPR match with EX or WB stalls.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int NREG = 14,
    parameter int IMMW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [31:0]          instr_in,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      overflow,
    input  logic [NREG*XLEN-1:0] r_flat,
    input  logic                 ex_wr_en,
    input  logic                 ex_is_load,
    input  logic [3:0]           ex_wr_idx,
    input  logic [XLEN-1:0]      ex_wr_data,
    input  logic                 wb_wr_en,
    input  logic [3:0]           wb_wr_idx,
    input  logic [XLEN-1:0]      wb_wr_data,
    input  logic                 stall,
    input  logic                 flush,
    output logic [XLEN-1:0]      a_val,
    output logic [XLEN-1:0]      b_val,
    output logic [31:0]          instr_out,
    output logic                 out_valid,
    output logic                 hazard_stall
);

    localparam logic [3:0] c_idx_pc  = 4'hE;
    localparam logic [3:0] c_idx_ovf = 4'hF;
    localparam logic [4:0] c_nreg    = 5'(NREG);

    // Instruction fields
    logic            w_imb;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [IMMW-1:0] w_imm;

    assign w_imb = instr_in[31];
    assign w_ra  = instr_in[30:27];
    assign w_rb  = instr_in[26:23];
    assign w_imm = instr_in[13 +: IMMW];

    // Which sources actually name a general register
    logic w_ra_gpr;
    logic w_rb_used;

    assign w_ra_gpr  = ({1'b0, w_ra} < c_nreg);
    assign w_rb_used = ~w_imb & ({1'b0, w_rb} < c_nreg);

    // Bypass and hazard qualifiers for the two build flavours
    logic w_ex_fwd;
    logic w_wb_fwd;
    logic w_ex_hz;
    logic w_wb_hz;

`ifdef OPERAND_FWD_EN
    // Non-load EX results and all WB results are bypassed; a load in EX has
    // no data yet, so only that case has to stall.
    assign w_ex_fwd = ex_wr_en & ~ex_is_load;
    assign w_wb_fwd = wb_wr_en;
    assign w_ex_hz  = ex_wr_en & ex_is_load;
    assign w_wb_hz  = 1'b0;
`else
    // Without bypass any pending write to a used GPR must drain first.
    assign w_ex_fwd = 1'b0;
    assign w_wb_fwd = 1'b0;
    assign w_ex_hz  = ex_wr_en;
    assign w_wb_hz  = wb_wr_en;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{ex_is_load, ex_wr_data, wb_wr_data};
`endif

    // Read one source index: PC, overflow, bypassed or plain GPR, else zero
    function automatic logic [XLEN-1:0] f_src(
        input logic [3:0]           idx,
        input logic [NREG*XLEN-1:0] regs,
        input logic [XLEN-1:0]      pc_v,
        input logic [XLEN-1:0]      ovf_v,
        input logic                 ex_hit,
        input logic [XLEN-1:0]      ex_d,
        input logic                 wb_hit,
        input logic [XLEN-1:0]      wb_d
    );
        logic [XLEN-1:0] v;
        v = '0;
        if (idx == c_idx_pc) begin
            v = pc_v;
        end else if (idx == c_idx_ovf) begin
            v = ovf_v;
        end else if (ex_hit) begin
            v = ex_d;
        end else if (wb_hit) begin
            v = wb_d;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (idx == 4'(i)) begin
                    v = regs[i*XLEN +: XLEN];
                end
            end
        end
        return v;
    endfunction

    // Bypass hits per source; only GPR indices can be bypassed
    logic w_a_ex_hit;
    logic w_a_wb_hit;
    logic w_b_ex_hit;
    logic w_b_wb_hit;

    assign w_a_ex_hit = w_ex_fwd & w_ra_gpr  & (ex_wr_idx == w_ra);
    assign w_a_wb_hit = w_wb_fwd & w_ra_gpr  & (wb_wr_idx == w_ra);
    assign w_b_ex_hit = w_ex_fwd & w_rb_used & (ex_wr_idx == w_rb);
    assign w_b_wb_hit = w_wb_fwd & w_rb_used & (wb_wr_idx == w_rb);

    // Hazard: a used GPR source collides with a write that cannot be bypassed
    logic w_ex_match;
    logic w_wb_match;

    assign w_ex_match = (w_ra_gpr & (ex_wr_idx == w_ra)) | (w_rb_used & (ex_wr_idx == w_rb));
    assign w_wb_match = (w_ra_gpr & (wb_wr_idx == w_ra)) | (w_rb_used & (wb_wr_idx == w_rb));

    assign hazard_stall = in_valid & ((w_ex_hz & w_ex_match) | (w_wb_hz & w_wb_match));

    // Sign-extend the immediate to XLEN
    logic [XLEN-1:0] w_imm_ext;

    // Replicate the sign bit, then overlay the immediate itself
    always_comb begin
        w_imm_ext             = {XLEN{w_imm[IMMW-1]}};
        w_imm_ext[IMMW-1:0]   = w_imm;
    end

    // Next operand values
    logic [XLEN-1:0] w_a_next;
    logic [XLEN-1:0] w_b_next;

    // A always reads Ra; B is the immediate or Rb, where PC/overflow codes read zero
    always_comb begin
        w_a_next = f_src(w_ra, r_flat, pc, overflow,
                         w_a_ex_hit, ex_wr_data, w_a_wb_hit, wb_wr_data);
        w_b_next = '0;
        if (w_imb) begin
            w_b_next = w_imm_ext;
        end else if (w_rb < c_idx_pc) begin
            w_b_next = f_src(w_rb, r_flat, pc, overflow,
                             w_b_ex_hit, ex_wr_data, w_b_wb_hit, wb_wr_data);
        end
    end

    // Pipeline register: reset > flush > stall (hold) > hazard bubble > capture
    logic [XLEN-1:0] r_a_val;
    logic [XLEN-1:0] r_b_val;
    logic [31:0]     r_instr;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_a_val <= '0;
            r_b_val <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_a_val <= r_a_val;
            r_b_val <= r_b_val;
            r_instr <= r_instr;
            r_valid <= r_valid;
        end else if (hazard_stall) begin
            r_a_val <= '0;
            r_b_val <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_a_val <= w_a_next;
            r_b_val <= w_b_next;
            r_instr <= instr_in;
            r_valid <= in_valid;
        end
    end

    assign a_val     = r_a_val;
    assign b_val     = r_b_val;
    assign instr_out = r_instr;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Self-checking bench for operand_fetch: directed vector table,
//            hand-written multi-cycle sequences and randomized cycles checked
//            against a behavioural model. Follows OPERAND_FWD_EN like the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int NREG = 14;
    localparam int IMMW = 14;
`ifdef OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 in_valid;
    logic [31:0]          instr_in;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      overflow;
    logic [NREG*XLEN-1:0] r_flat;
    logic                 ex_wr_en;
    logic                 ex_is_load;
    logic [3:0]           ex_wr_idx;
    logic [XLEN-1:0]      ex_wr_data;
    logic                 wb_wr_en;
    logic [3:0]           wb_wr_idx;
    logic [XLEN-1:0]      wb_wr_data;
    logic                 stall;
    logic                 flush;
    logic [XLEN-1:0]      a_val;
    logic [XLEN-1:0]      b_val;
    logic [31:0]          instr_out;
    logic                 out_valid;
    logic                 hazard_stall;

    logic [XLEN-1:0] regs [NREG];

    // Pack the bench's register array into the flat bus
    always_comb begin
        r_flat = '0;
        for (int i = 0; i < NREG; i++) r_flat[i*XLEN +: XLEN] = regs[i];
    end

    operand_fetch #(.XLEN(XLEN), .NREG(NREG), .IMMW(IMMW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr_in(instr_in),
        .pc(pc), .overflow(overflow), .r_flat(r_flat),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_idx(ex_wr_idx),
        .ex_wr_data(ex_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_idx(wb_wr_idx),
        .wb_wr_data(wb_wr_data), .stall(stall), .flush(flush),
        .a_val(a_val), .b_val(b_val), .instr_out(instr_out),
        .out_valid(out_valid), .hazard_stall(hazard_stall)
    );

    int checks = 0;
    int errors = 0;

    // Model of the registered outputs
    logic [31:0] m_a, m_b, m_instr;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic imb, input logic [3:0] ra, input logic [13:0] imm);
        return {imb, ra, imm, 5'h0A, 4'h3, 3'b101, 1'b1};
    endfunction

    // Value seen for a source index, from the architectural rules
    function automatic logic [31:0] ref_src(input int idx);
        if (idx == 14) return pc;
        if (idx == 15) return overflow;
        if (idx >= NREG) return 32'h0;
        if (FWD && ex_wr_en && !ex_is_load && int'(ex_wr_idx) == idx) return ex_wr_data;
        if (FWD && wb_wr_en && int'(wb_wr_idx) == idx) return wb_wr_data;
        return regs[idx];
    endfunction

    function automatic logic [31:0] ref_b();
        logic signed [13:0] s;
        int rb;
        s  = instr_in[26:13];
        rb = int'(instr_in[26:23]);
        if (instr_in[31]) return 32'(s);
        if (rb < 14) return ref_src(rb);
        return 32'h0;
    endfunction

    function automatic logic ref_hazard();
        int  used[$];
        logic hz;
        hz = 1'b0;
        if (!in_valid) return 1'b0;
        used.push_back(int'(instr_in[30:27]));
        if (!instr_in[31]) used.push_back(int'(instr_in[26:23]));
        foreach (used[k]) begin
            if (used[k] < NREG) begin
                if (FWD)
                    hz = hz | (ex_wr_en && ex_is_load && int'(ex_wr_idx) == used[k]);
                else
                    hz = hz | (ex_wr_en && int'(ex_wr_idx) == used[k])
                            | (wb_wr_en && int'(wb_wr_idx) == used[k]);
            end
        end
        return hz;
    endfunction

    // One clock: check combinational hazard, advance model, check registered outputs
    task automatic step(input string tag);
        logic        hz;
        logic [31:0] na, nb;
        #1;
        hz = ref_hazard();
        chk($sformatf("%s hazard_stall", tag), 32'(hazard_stall), 32'(hz));
        na = ref_src(int'(instr_in[30:27]));
        nb = ref_b();
        @(posedge clk);
        if (rst || flush || (!stall && hz)) begin
            m_a = 0; m_b = 0; m_instr = 0; m_valid = 0;
        end else if (!stall) begin
            m_a = na; m_b = nb; m_instr = instr_in; m_valid = in_valid;
        end
        #1;
        chk($sformatf("%s a_val", tag), a_val, m_a);
        chk($sformatf("%s b_val", tag), b_val, m_b);
        chk($sformatf("%s instr_out", tag), instr_out, m_instr);
        chk($sformatf("%s out_valid", tag), 32'(out_valid), 32'(m_valid));
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_idx = 0; ex_wr_data = 0;
        wb_wr_en = 0; wb_wr_idx = 0; wb_wr_data = 0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] ei, input logic ev);
        chk($sformatf("%s lit a", tag), a_val, ea);
        chk($sformatf("%s lit b", tag), b_val, eb);
        chk($sformatf("%s lit instr", tag), instr_out, ei);
        chk($sformatf("%s lit valid", tag), 32'(out_valid), 32'(ev));
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic [31:0] vpc;
        logic [31:0] vovf;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{mk(1, 4'd3, 14'h3FFF),           1'b1, 32'h40,   32'h7,        32'h11,       32'hFFFF_FFFF};
        tbl[1] = '{mk(1, 4'hE, 14'h0005),           1'b1, 32'h40,   32'h7,        32'h40,       32'h5};
        tbl[2] = '{mk(0, 4'hF, {4'hF, 10'h0}),      1'b1, 32'h40,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{mk(0, 4'd0, {4'hE, 10'h0}),      1'b1, 32'h40,   32'h7,        32'h1000,     32'h0};
        tbl[4] = '{mk(0, 4'd13, {4'd2, 10'h3FF}),   1'b1, 32'h40,   32'h7,        32'h100D,     32'h1002};
        tbl[5] = '{mk(1, 4'd1, 14'h2000),           1'b1, 32'h40,   32'h7,        32'h1001,     32'hFFFF_E000};
        tbl[6] = '{mk(1, 4'hE, 14'h1FFF),           1'b1, 32'h1234, 32'h7,        32'h1234,     32'h1FFF};
        tbl[7] = '{mk(1, 4'd3, 14'h0005),           1'b0, 32'h40,   32'h7,        32'h11,       32'h5};

        for (int i = 0; i < NREG; i++) regs[i] = 32'h1000 + 32'(i);
        regs[3] = 32'h11;
        idle();
        pc = 32'h40; overflow = 32'h7;

        // Reset held two cycles with a live instruction presented
        rst = 1; in_valid = 1; instr_in = mk(1, 4'd3, 14'h3FFF);
        step("rst0"); chk_out("rst0", 0, 0, 0, 0);
        step("rst1"); chk_out("rst1", 0, 0, 0, 0);
        rst = 0;

        // Directed field-select vectors; first one is the first edge after reset
        for (int i = 0; i < 8; i++) begin
            idle();
            instr_in = tbl[i].instr; in_valid = tbl[i].v;
            pc = tbl[i].vpc; overflow = tbl[i].vovf;
            step($sformatf("vec%0d", i));
            chk_out($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].instr, tbl[i].v);
        end

        // Stall holds for three cycles while inputs change; then flush beats stall
        idle(); in_valid = 1; instr_in = tbl[0].instr; pc = 32'h40;
        step("stl_cap");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            instr_in = mk(1, 4'd1, 14'($urandom)); pc = $urandom; in_valid = $urandom_range(0, 1);
            step($sformatf("stall%0d", i));
            chk_out($sformatf("stall%0d", i), 32'h11, 32'hFFFF_FFFF, tbl[0].instr, 1'b1);
        end
        flush = 1;
        step("stl_fl"); chk_out("stl_fl", 0, 0, 0, 0);
        idle();

`ifdef OPERAND_FWD_EN
        // EX beats WB beats register file, same GPR on both operands
        regs[5] = 32'h1; in_valid = 1; instr_in = mk(0, 4'd5, {4'd5, 10'h0});
        wb_wr_en = 1; wb_wr_idx = 5; wb_wr_data = 32'h2;
        ex_wr_en = 1; ex_wr_idx = 5; ex_wr_data = 32'h3;
        step("byp_ex"); chk_out("byp_ex", 32'h3, 32'h3, instr_in, 1'b1);
        ex_wr_en = 0;
        step("byp_wb"); chk_out("byp_wb", 32'h2, 32'h2, instr_in, 1'b1);
        idle();

        // Load-use: bubble, then pick the load result up from WB
        instr_in = mk(1, 4'd7, 14'h0); in_valid = 1;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_idx = 7; ex_wr_data = 32'h55;
        #1; chk("lu hz lit", 32'(hazard_stall), 32'h1);
        step("lu_bub"); chk_out("lu_bub", 0, 0, 0, 0);
        ex_wr_en = 0; ex_is_load = 0;
        wb_wr_en = 1; wb_wr_idx = 7; wb_wr_data = 32'h99;
        #1; chk("lu clr lit", 32'(hazard_stall), 32'h0);
        step("lu_wb"); chk_out("lu_wb", 32'h99, 32'h0, instr_in, 1'b1);
        idle();

        // Immediate form: Rb field matching the load is not a used source
        instr_in = mk(1, 4'd2, {4'd7, 10'h0}); in_valid = 1;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_idx = 7;
        #1; chk("lu imm lit", 32'(hazard_stall), 32'h0);
        step("lu_imm"); chk_out("lu_imm", 32'h1002, 32'h1C00, instr_in, 1'b1);
        idle();
`else
        // No bypass: a pending WB write to a used GPR stalls and bubbles
        instr_in = mk(1, 4'd4, 14'h0); in_valid = 1;
        wb_wr_en = 1; wb_wr_idx = 4; wb_wr_data = 32'h77;
        #1; chk("nf wb lit", 32'(hazard_stall), 32'h1);
        step("nf_wb"); chk_out("nf_wb", 0, 0, 0, 0);
        // Same for EX regardless of load flag, via Rb
        idle(); instr_in = mk(0, 4'd2, {4'd9, 10'h0});
        ex_wr_en = 1; ex_wr_idx = 9;
        #1; chk("nf ex lit", 32'(hazard_stall), 32'h1);
        step("nf_ex"); chk_out("nf_ex", 0, 0, 0, 0);
        // Rb field not used with Imb=1: no hazard, operands from r_flat
        idle(); instr_in = mk(1, 4'd2, {4'd4, 10'h0});
        wb_wr_en = 1; wb_wr_idx = 4;
        #1; chk("nf imm lit", 32'(hazard_stall), 32'h0);
        step("nf_imm"); chk_out("nf_imm", 32'h1002, 32'h1000, instr_in, 1'b1);
        idle();
`endif

        // Randomized cycles against the model
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            instr_in = $urandom; pc = $urandom; overflow = $urandom;
            ex_wr_en = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
            ex_wr_idx = ($urandom_range(0, 2) == 0) ? instr_in[30:27] : 4'($urandom_range(0, 15));
            ex_wr_data = $urandom;
            wb_wr_en = $urandom_range(0, 1);
            wb_wr_idx = ($urandom_range(0, 2) == 0) ? instr_in[26:23] : 4'($urandom_range(0, 15));
            wb_wr_data = $urandom;
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < NREG; i++) regs[i] = $urandom;
            step($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
# operand_fetch

Parametrised decode/operand-fetch pipeline stage for the WolfCore integer pipeline. It sits between fetch and execute and splits the 32-bit instruction word into its fields. It selects A/B operands from the register file, PC, overflow register or the sign-extended immediate, and bypasses in-flight results from execute and writeback. It also detects load-use hazards and applies stall/flush control with a valid handshake, all registered into the execute stage.

## Interface
- XLEN, 32, operand/data width (≥ IMMW).
- NREG, 14, general registers r0..r(NREG-1); 1 ≤ NREG ≤ 14.
- IMMW, 14, immediate width, sign-extended to XLEN; IMMW ≤ 14.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instr_in holds a real instruction.
- instr_in  in  32  {Imb[31], Ra[30:27], Imm[26:13], Opc[12:8], Rc[7:4], Cond[3:1], Cmp[0]}; Rb = [26:23].
- pc  in  XLEN  PC of instr_in.
- overflow  in  XLEN  overflow register.
- r_flat  in  NREG*XLEN  register file, r[i] = r_flat[i*XLEN +: XLEN].
- ex_wr_en, ex_is_load  in  1 each  execute stage will write ex_wr_idx; result is a load (data not yet available).
- ex_wr_idx  in  4 ; ex_wr_data  in  XLEN.
- wb_wr_en  in  1 ; wb_wr_idx  in  4 ; wb_wr_data  in  XLEN.
- stall  in  1  downstream hold.
- flush  in  1  branch redirect; kill stage contents.
- a_val, b_val  out  XLEN  registered operands.
- instr_out  out  32  registered instruction.
- out_valid  out  1  registered valid.
- hazard_stall  out  1  combinational; upstream must hold instr_in.

## Operation
- Index 0xE selects pc. Index 0xF selects overflow. Index < NREG selects r[idx]. NREG ≤ idx < 0xE reads 0.
- A source: Ra, always used.
- B source:
  - Imb=1: b_val = sign-extended Imm[IMMW-1:0]; bits above IMMW are ignored.
  - Imb=0: Rb if Rb < 0xE, else 0. 0xE/0xF are not valid B sources.
- Bypass applies only to GPR indices (< NREG). Priority for a GPR: EX (ex_wr_en, not load, idx match) > WB (wb_wr_en, idx match) > r_flat.
- Load-use hazard: in_valid & ex_wr_en & ex_is_load & ex_wr_idx matches a used GPR source. The result is hazard_stall=1, and the stage registers a bubble: out_valid=0, instr_out=0, a_val/b_val=0.
- A used source means Ra, or Rb when Imb=0.

## Timing
- Latency 1 cycle: fields presented at edge N appear on outputs after edge N.
- Per-edge priority:
  - rst: all outputs 0.
  - flush: bubble (all outputs 0); flush overrides stall.
  - stall: all outputs hold; hazard_stall is still computed but has no effect on the outputs.
  - hazard: bubble.
  - otherwise: capture; out_valid = in_valid, and instr_out = instr_in even when in_valid=0.
- Reset values: a_val=0, b_val=0, instr_out=0, out_valid=0. hazard_stall depends only on inputs, so it is 0 whenever in_valid=0.
- hazard_stall is combinational from in_valid, instr_in and the ex_* inputs, within the same cycle. It is not gated by stall or flush; upstream combines them.
- A hazard clears the cycle after the load leaves EX. The held instruction then picks up the load result from the WB bypass.
- Same index on EX and WB: EX wins. Same GPR used as both Ra and Rb: both operands get the bypassed value.

## Configuration
- OPERAND_FWD_EN defined: EX/WB bypass as above; only load-use raises hazard_stall.
- OPERAND_FWD_EN undefined: no bypass; operands always come from r_flat. hazard_stall is raised on any used-GPR match with EX (ex_wr_en) or WB (wb_wr_en), regardless of ex_is_load, and a bubble is inserted.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 → all outputs 0, out_valid=0. First edge after release captures normally.
- Field select: r3=0x11, Ra=3, Imb=1, Imm=0x3FFF → a_val=0x11, b_val=0xFFFFFFFF. Ra=0xE with pc=0x40 → a_val=0x40. Ra=0xF → overflow. Imb=0, Rb=0xF → b_val=0.
- Bypass (FWD_EN): r5=1, wb writes r5=2, ex writes r5=3 (not load), Ra=Rb=5 → a_val=b_val=3. Remove EX → 2.
- Load-use: ex_is_load, ex_wr_idx=7, Ra=7 → hazard_stall=1, next out_valid=0, instr_out=0. Next cycle ex idle, wb writes r7=0x99 → a_val=0x99, out_valid=1. Same case with Imb=1 and Rb field=7, Ra=2 → no hazard.
- Stall/flush: stall=1 for 3 cycles → outputs constant. stall=1 with flush=1 → bubble.
- Without OPERAND_FWD_EN: wb_wr_en, wb_wr_idx=4, Ra=4 → hazard_stall=1, bubble.
